rgmii_rx_framer: RTL and testbench

- Sits directly downstream of the RGMII receive IDDR stage.
- Takes the same-cycle rising/falling nibble and control pairs and rebuilds GMII bytes.
- Strips preamble/SFD and emits each frame as a registered byte stream with last and error markers, plus per-frame status pulses.
- Gigabit only; the PHY cannot be stalled, so there is no backpressure.

---
 rtl/rgmii_rx_framer.sv | 160 ++++++++++++++++
 tb/tb_rgmii_rx_framer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_framer.sv
// rtl/rgmii_rx_framer.sv - RGMII receive framer: rebuilds GMII bytes, strips preamble/SFD, emits framed byte stream
module rgmii_rx_framer #(
    parameter int MIN_PREAMBLE = 1,
    parameter int MAX_LEN      = 1522
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] rxd_rise,
    input  logic [3:0] rxd_fall,
    input  logic       rx_ctl_rise,
    input  logic       rx_ctl_fall,
    output logic [7:0] m_tdata,
    output logic       m_tvalid,
    output logic       m_tlast,
    output logic       m_tuser,
    output logic       stat_frame,
    output logic       stat_bad_pre,
    output logic       stat_oversize
);
    localparam int CW = $clog2(MAX_LEN + 1);
    localparam logic [CW-1:0] LP_MAX_LEN = CW'(MAX_LEN);
    localparam logic [2:0]    LP_MIN_PRE = 3'(MIN_PREAMBLE);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DISCARD} state_t;

    logic [7:0] w_byte;
    logic       w_dv;
    logic       w_er;

    state_t        r_state;
    logic          r_dv_prev;
    logic [2:0]    r_pre_cnt;
    logic [7:0]    r_hold;
    logic          r_hold_vld;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic [7:0]    r_tdata;
    logic          r_tvalid;
    logic          r_tlast;
    logic          r_tuser;
    logic          r_stat_frame;
    logic          r_stat_bad_pre;
    logic          r_stat_oversize;

    assign w_byte = {rxd_fall, rxd_rise};
    assign w_dv   = rx_ctl_rise;
    assign w_er   = rx_ctl_rise ^ rx_ctl_fall;

    assign m_tdata       = r_tdata;
    assign m_tvalid      = r_tvalid;
    assign m_tlast       = r_tlast;
    assign m_tuser       = r_tuser;
    assign stat_frame    = r_stat_frame;
    assign stat_bad_pre  = r_stat_bad_pre;
    assign stat_oversize = r_stat_oversize;

    // dv_prev resets high so a frame already running at reset release is ignored until dv drops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_dv_prev       <= 1'b1;
            r_pre_cnt       <= 3'd0;
            r_hold          <= 8'h00;
            r_hold_vld      <= 1'b0;
            r_cnt           <= '0;
            r_err           <= 1'b0;
            r_tdata         <= 8'h00;
            r_tvalid        <= 1'b0;
            r_tlast         <= 1'b0;
            r_tuser         <= 1'b0;
            r_stat_frame    <= 1'b0;
            r_stat_bad_pre  <= 1'b0;
            r_stat_oversize <= 1'b0;
        end else begin
            r_dv_prev       <= w_dv;
            r_tvalid        <= 1'b0;
            r_tlast         <= 1'b0;
            r_tuser         <= 1'b0;
            r_stat_frame    <= 1'b0;
            r_stat_bad_pre  <= 1'b0;
            r_stat_oversize <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_dv && !r_dv_prev) begin
                        if (!w_er && w_byte == 8'h55) begin
                            r_state   <= S_PREAMBLE;
                            r_pre_cnt <= 3'd1;
                        end else if (!w_er && w_byte == 8'hD5 && MIN_PREAMBLE == 0) begin
                            r_state    <= S_DATA;
                            r_cnt      <= '0;
                            r_err      <= 1'b0;
                            r_hold_vld <= 1'b0;
                        end else begin
                            r_state        <= S_DISCARD;
                            r_stat_bad_pre <= 1'b1;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!w_dv) begin
                        r_state <= S_IDLE;
                    end else if (w_er) begin
                        r_state        <= S_DISCARD;
                        r_stat_bad_pre <= 1'b1;
                    end else if (w_byte == 8'h55) begin
                        if (r_pre_cnt != 3'd7) begin
                            r_pre_cnt <= r_pre_cnt + 3'd1;
                        end
                    end else if (w_byte == 8'hD5 && r_pre_cnt >= LP_MIN_PRE) begin
                        r_state    <= S_DATA;
                        r_cnt      <= '0;
                        r_err      <= w_er;
                        r_hold_vld <= 1'b0;
                    end else begin
                        r_state        <= S_DISCARD;
                        r_stat_bad_pre <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (!w_dv) begin
                        if (r_hold_vld) begin
                            r_tdata      <= r_hold;
                            r_tvalid     <= 1'b1;
                            r_tlast      <= 1'b1;
                            r_tuser      <= r_err;
                            r_stat_frame <= 1'b1;
                        end
                        r_hold_vld <= 1'b0;
                        r_state    <= S_IDLE;
                    end else if (r_cnt == LP_MAX_LEN) begin
                        // hold is the MAX_LEN-th byte; close the frame on it and drop the overflow
                        r_tdata         <= r_hold;
                        r_tvalid        <= 1'b1;
                        r_tlast         <= 1'b1;
                        r_tuser         <= 1'b1;
                        r_stat_frame    <= 1'b1;
                        r_stat_oversize <= 1'b1;
                        r_hold_vld      <= 1'b0;
                        r_state         <= S_DISCARD;
                    end else begin
                        if (r_hold_vld) begin
                            r_tdata  <= r_hold;
                            r_tvalid <= 1'b1;
                        end
                        r_hold     <= w_byte;
                        r_hold_vld <= 1'b1;
                        r_cnt      <= r_cnt + CW'(1);
                        r_err      <= r_err | w_er;
                    end
                end
                S_DISCARD: begin
                    if (!w_dv) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rgmii_rx_framer.sv
// tb/tb_rgmii_rx_framer.sv - directed testbench for rgmii_rx_framer (default and MIN_PREAMBLE=2/MAX_LEN=16 instances)
module tb_rgmii_rx_framer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] rxd_rise = 4'h0;
    logic [3:0] rxd_fall = 4'h0;
    logic       rx_ctl_rise = 1'b0;
    logic       rx_ctl_fall = 1'b0;

    logic [7:0] a_tdata, b_tdata;
    logic       a_tvalid, a_tlast, a_tuser, a_frame, a_badp, a_over;
    logic       b_tvalid, b_tlast, b_tuser, b_frame, b_badp, b_over;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [9:0] a_q[$];
    logic [9:0] b_q[$];
    int a_t[$];
    int b_t[$];
    int cap[$];
    int a_frames = 0, a_badps = 0, a_overs = 0;
    int b_frames = 0, b_badps = 0, b_overs = 0;

    rgmii_rx_framer #(.MIN_PREAMBLE(1), .MAX_LEN(1522)) dut_a (
        .clk(clk), .rst_n(rst_n), .rxd_rise(rxd_rise), .rxd_fall(rxd_fall),
        .rx_ctl_rise(rx_ctl_rise), .rx_ctl_fall(rx_ctl_fall),
        .m_tdata(a_tdata), .m_tvalid(a_tvalid), .m_tlast(a_tlast), .m_tuser(a_tuser),
        .stat_frame(a_frame), .stat_bad_pre(a_badp), .stat_oversize(a_over)
    );

    rgmii_rx_framer #(.MIN_PREAMBLE(2), .MAX_LEN(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .rxd_rise(rxd_rise), .rxd_fall(rxd_fall),
        .rx_ctl_rise(rx_ctl_rise), .rx_ctl_fall(rx_ctl_fall),
        .m_tdata(b_tdata), .m_tvalid(b_tvalid), .m_tlast(b_tlast), .m_tuser(b_tuser),
        .stat_frame(b_frame), .stat_bad_pre(b_badp), .stat_oversize(b_over)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (a_tvalid) begin
            a_q.push_back({a_tuser, a_tlast, a_tdata});
            a_t.push_back(cyc);
        end
        if (b_tvalid) begin
            b_q.push_back({b_tuser, b_tlast, b_tdata});
            b_t.push_back(cyc);
        end
        if (a_frame) a_frames++;
        if (a_badp)  a_badps++;
        if (a_over)  a_overs++;
        if (b_frame) b_frames++;
        if (b_badp)  b_badps++;
        if (b_over)  b_overs++;
    end

    task automatic step(input logic dv, input logic er, input logic [7:0] b);
        rxd_rise    = b[3:0];
        rxd_fall    = b[7:4];
        rx_ctl_rise = dv;
        rx_ctl_fall = dv ^ er;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_frame(input int npre, input logic [7:0] first, input int n, input int err_idx);
        for (int i = 0; i < npre; i++) step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        for (int j = 0; j < n; j++) begin
            step(1'b1, (j == err_idx), 8'(first + j));
            cap.push_back(cyc);
        end
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h55);
        total++;
        if ({a_tdata, a_tvalid, a_tlast, a_tuser, a_frame, a_badp, a_over} !== 14'h0) begin
            bad++;
            $display("FAIL reset_a got=%h exp=0", {a_tdata, a_tvalid, a_tlast, a_tuser, a_frame, a_badp, a_over});
        end
        total++;
        if ({b_tdata, b_tvalid, b_tlast, b_tuser, b_frame, b_badp, b_over} !== 14'h0) begin
            bad++;
            $display("FAIL reset_b got=%h exp=0", {b_tdata, b_tvalid, b_tlast, b_tuser, b_frame, b_badp, b_over});
        end
        step(1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_basic;
        int q0, c0, f0, p0;
        logic [9:0] e;
        q0 = a_q.size(); c0 = cap.size(); f0 = a_frames; p0 = a_badps;
        drive_frame(7, 8'h01, 64, -1);
        step(1'b0, 1'b0, 8'h00);
        total++;
        if (a_q.size() - q0 != 64) begin
            bad++;
            $display("FAIL basic_beats got=%0d exp=64", a_q.size() - q0);
        end
        for (int j = 0; j < 64 && q0 + j < a_q.size(); j++) begin
            e = {1'b0, (j == 63), 8'(j + 1)};
            total++;
            if (a_q[q0 + j] !== e) begin
                bad++;
                $display("FAIL basic_beat[%0d] got=%h exp=%h", j, a_q[q0 + j], e);
            end
            total++;
            if (a_t[q0 + j] !== cap[c0 + j] + 1) begin
                bad++;
                $display("FAIL basic_latency[%0d] got=%0d exp=%0d", j, a_t[q0 + j], cap[c0 + j] + 1);
            end
        end
        total++;
        if (a_frames - f0 != 1) begin
            bad++;
            $display("FAIL basic_frames got=%0d exp=1", a_frames - f0);
        end
        total++;
        if (a_badps - p0 != 0) begin
            bad++;
            $display("FAIL basic_badpre got=%0d exp=0", a_badps - p0);
        end
    endtask

    task automatic test_err_byte;
        int q0, f0;
        logic [9:0] e;
        q0 = a_q.size(); f0 = a_frames;
        drive_frame(7, 8'h01, 64, 9);
        step(1'b0, 1'b0, 8'h00);
        total++;
        if (a_q.size() - q0 != 64) begin
            bad++;
            $display("FAIL err_beats got=%0d exp=64", a_q.size() - q0);
        end
        for (int j = 0; j < 64 && q0 + j < a_q.size(); j++) begin
            e = {(j == 63), (j == 63), 8'(j + 1)};
            total++;
            if (a_q[q0 + j] !== e) begin
                bad++;
                $display("FAIL err_beat[%0d] got=%h exp=%h", j, a_q[q0 + j], e);
            end
        end
        total++;
        if (a_frames - f0 != 1) begin
            bad++;
            $display("FAIL err_frames got=%0d exp=1", a_frames - f0);
        end
    endtask

    task automatic test_bad_preamble;
        int q0, p0, f0, fa0;
        logic [9:0] e;
        q0 = b_q.size(); p0 = b_badps; f0 = b_frames; fa0 = a_frames;
        drive_frame(1, 8'h01, 8, -1);
        total++;
        if (b_q.size() != q0) begin
            bad++;
            $display("FAIL badpre_nobeats got=%0d exp=0", b_q.size() - q0);
        end
        total++;
        if (b_badps - p0 != 1) begin
            bad++;
            $display("FAIL badpre_pulse got=%0d exp=1", b_badps - p0);
        end
        drive_frame(7, 8'h80, 10, -1);
        step(1'b0, 1'b0, 8'h00);
        total++;
        if (b_q.size() - q0 != 10) begin
            bad++;
            $display("FAIL badpre_next_beats got=%0d exp=10", b_q.size() - q0);
        end
        for (int j = 0; j < 10 && q0 + j < b_q.size(); j++) begin
            e = {1'b0, (j == 9), 8'(8'h80 + j)};
            total++;
            if (b_q[q0 + j] !== e) begin
                bad++;
                $display("FAIL badpre_next_beat[%0d] got=%h exp=%h", j, b_q[q0 + j], e);
            end
        end
        total++;
        if (b_frames - f0 != 1 || b_badps - p0 != 1) begin
            bad++;
            $display("FAIL badpre_counts got=%0d/%0d exp=1/1", b_frames - f0, b_badps - p0);
        end
        total++;
        if (a_frames - fa0 != 2) begin
            bad++;
            $display("FAIL badpre_min1_frames got=%0d exp=2", a_frames - fa0);
        end
    endtask

    task automatic test_oversize;
        int q0, c0, f0, o0;
        logic [9:0] e;
        q0 = b_q.size(); c0 = cap.size(); f0 = b_frames; o0 = b_overs;
        drive_frame(7, 8'h10, 20, -1);
        drive_frame(3, 8'hA0, 5, -1);
        step(1'b0, 1'b0, 8'h00);
        total++;
        if (b_q.size() - q0 != 21) begin
            bad++;
            $display("FAIL over_beats got=%0d exp=21", b_q.size() - q0);
        end
        for (int j = 0; j < 16 && q0 + j < b_q.size(); j++) begin
            e = {(j == 15), (j == 15), 8'(8'h10 + j)};
            total++;
            if (b_q[q0 + j] !== e) begin
                bad++;
                $display("FAIL over_beat[%0d] got=%h exp=%h", j, b_q[q0 + j], e);
            end
            total++;
            if (b_t[q0 + j] !== cap[c0 + j] + 1) begin
                bad++;
                $display("FAIL over_latency[%0d] got=%0d exp=%0d", j, b_t[q0 + j], cap[c0 + j] + 1);
            end
        end
        for (int j = 0; j < 5 && q0 + 16 + j < b_q.size(); j++) begin
            e = {1'b0, (j == 4), 8'(8'hA0 + j)};
            total++;
            if (b_q[q0 + 16 + j] !== e) begin
                bad++;
                $display("FAIL over_next_beat[%0d] got=%h exp=%h", j, b_q[q0 + 16 + j], e);
            end
        end
        total++;
        if (b_overs - o0 != 1) begin
            bad++;
            $display("FAIL over_pulse got=%0d exp=1", b_overs - o0);
        end
        total++;
        if (b_frames - f0 != 2) begin
            bad++;
            $display("FAIL over_frames got=%0d exp=2", b_frames - f0);
        end
    endtask

    task automatic test_reset_mid;
        int q0, f0, p0;
        logic [9:0] e;
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        for (int j = 0; j < 5; j++) step(1'b1, 1'b0, 8'(j + 1));
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({a_tdata, a_tvalid, a_tlast, a_tuser, a_frame, a_badp, a_over} !== 14'h0) begin
                bad++;
                $display("FAIL midreset_zero[%0d] got=%h exp=0", k, {a_tdata, a_tvalid, a_tlast, a_tuser, a_frame, a_badp, a_over});
            end
            step(1'b1, 1'b0, 8'h55);
        end
        q0 = a_q.size(); f0 = a_frames; p0 = a_badps;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h55);
        step(1'b1, 1'b0, 8'hD5);
        for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 8'(j + 1));
        step(1'b0, 1'b0, 8'h00);
        total++;
        if (a_q.size() != q0 || a_frames != f0 || a_badps != p0) begin
            bad++;
            $display("FAIL midreset_ignored got=%0d/%0d/%0d exp=0/0/0", a_q.size() - q0, a_frames - f0, a_badps - p0);
        end
        drive_frame(7, 8'h30, 6, -1);
        step(1'b0, 1'b0, 8'h00);
        total++;
        if (a_q.size() - q0 != 6) begin
            bad++;
            $display("FAIL midreset_next_beats got=%0d exp=6", a_q.size() - q0);
        end
        for (int j = 0; j < 6 && q0 + j < a_q.size(); j++) begin
            e = {1'b0, (j == 5), 8'(8'h30 + j)};
            total++;
            if (a_q[q0 + j] !== e) begin
                bad++;
                $display("FAIL midreset_next_beat[%0d] got=%h exp=%h", j, a_q[q0 + j], e);
            end
        end
    endtask

    task automatic test_short_and_carrier;
        int qa, qb, pa, pb;
        logic [9:0] e;
        qa = a_q.size(); qb = b_q.size();
        pa = a_frames + a_badps + a_overs;
        pb = b_frames + b_badps + b_overs;
        drive_frame(7, 8'h00, 0, -1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h0F);
        drive_frame(2, 8'h00, 0, -1);
        step(1'b0, 1'b1, 8'h0F);
        total++;
        if (a_q.size() != qa || a_frames + a_badps + a_overs != pa) begin
            bad++;
            $display("FAIL short_a got=%0d beats %0d pulses exp=0/0", a_q.size() - qa, a_frames + a_badps + a_overs - pa);
        end
        total++;
        if (b_q.size() != qb || b_frames + b_badps + b_overs != pb) begin
            bad++;
            $display("FAIL short_b got=%0d beats %0d pulses exp=0/0", b_q.size() - qb, b_frames + b_badps + b_overs - pb);
        end
        drive_frame(7, 8'hC0, 3, -1);
        step(1'b0, 1'b0, 8'h00);
        total++;
        if (a_q.size() - qa != 3) begin
            bad++;
            $display("FAIL short_next_beats got=%0d exp=3", a_q.size() - qa);
        end
        for (int j = 0; j < 3 && qa + j < a_q.size(); j++) begin
            e = {1'b0, (j == 2), 8'(8'hC0 + j)};
            total++;
            if (a_q[qa + j] !== e) begin
                bad++;
                $display("FAIL short_next_beat[%0d] got=%h exp=%h", j, a_q[qa + j], e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err_byte();
        test_bad_preamble();
        test_oversize();
        test_reset_mid();
        test_short_and_carrier();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
